// File: rtl/anode_scan_driver_if.sv
// rtl/anode_scan_driver_if.sv - data/enable inputs and anode/segment outputs of the scan driver
// Display-side bundle; the register side drives Data/EN, the driver returns An/Seg/Frame_Done.
interface anode_scan_driver_if #(
    parameter int ANCHO = 4
);
    localparam int W = 2 ** ANCHO;
    localparam int D = W / 4;

    logic [W-1:0] Data;
    logic         EN;
    logic [D-1:0] An;
    logic [6:0]   Seg;
    logic         Frame_Done;

    modport master (output Data, output EN, input An, input Seg, input Frame_Done);
    modport slave  (input Data, input EN, output An, output Seg, output Frame_Done);
endinterface

// File: rtl/anode_scan_driver.sv
// rtl/anode_scan_driver.sv - frame-coherent 7-segment anode scanner (ANODE_LZB_EN: leading-zero blanking)
// Data is snapshotted only in IDLE and at frame wrap, so register writes never tear a frame.
module anode_scan_driver #(
    parameter int ANCHO    = 4,
    parameter int PRESCALE = 50000
) (
    input  logic               clk,
    input  logic               rst,
    anode_scan_driver_if.slave bus
);
    localparam int W  = 2 ** ANCHO;
    localparam int D  = W / 4;
    localparam int PW = $clog2(PRESCALE);
    localparam int IW = (D > 1) ? $clog2(D) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  snap_q, snap_d;
    logic [D-1:0]  an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          done_q, done_d;
    logic          tick, last, blank;
    logic [3:0]    nib;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    assign tick = (presc_q == PW'(PRESCALE - 1));
    assign last = (idx_q == IW'(D - 1));
    assign nib  = snap_q[int'(idx_q) * 4 +: 4];

    // EN low takes priority over every SCAN action, including the frame wrap.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        done_d  = 1'b0;
        if (state_q == ST_IDLE || !bus.EN) begin
            state_d = bus.EN ? ST_SCAN : ST_IDLE;
            presc_d = '0;
            idx_d   = '0;
            snap_d  = bus.Data;
        end else if (tick) begin
            presc_d = '0;
            idx_d   = last ? '0 : idx_q + IW'(1);
            if (last) begin
                snap_d = bus.Data;
                done_d = 1'b1;
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

`ifdef ANODE_LZB_EN
    logic [IW-1:0] msn;
    always_comb begin
        msn = '0;
        for (int k = 0; k < D; k++) begin
            if (snap_q[k * 4 +: 4] != 4'h0) msn = IW'(k);
        end
    end
    assign blank = (idx_q > msn);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        an_d  = '1;
        seg_d = 7'h7F;
        if (state_q == ST_SCAN && bus.EN && !blank) begin
            an_d  = ~(D'(1) << idx_q);
            seg_d = seg_decode(nib);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            an_q    <= '1;
            seg_q   <= 7'h7F;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            done_q  <= done_d;
        end
    end

    assign bus.An         = an_q;
    assign bus.Seg        = seg_q;
    assign bus.Frame_Done = done_q;
endmodule

// File: tb/tb_anode_scan_driver.sv
// tb/tb_anode_scan_driver.sv - directed bench for anode_scan_driver, PRESCALE=4, 4 digits
// Expected values follow ANODE_LZB_EN when the bench is built with it.
module tb_anode_scan_driver;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    anode_scan_driver_if #(.ANCHO(4)) bus ();

    anode_scan_driver #(.ANCHO(4), .PRESCALE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One full 16-cycle frame of word; Data is changed to chg_data after step chg_i.
    task automatic frame(input string tag, input logic [15:0] word, input int chg_i,
                         input logic [15:0] chg_data);
        logic [15:0] w;
        int d;
        w = word;
        for (int i = 0; i < 16; i++) begin
            tick();
            d = i / 4;
            chk({tag, "_an"}, bus.An, 4'hF ^ (4'b0001 << d));
            chk({tag, "_seg"}, bus.Seg, seg_tab[w[d*4 +: 4]]);
            chk({tag, "_fd"}, bus.Frame_Done, (i == 15) ? 1 : 0);
            if (i == chg_i) bus.Data = chg_data;
        end
    endtask

    initial begin
        logic [15:0] w;
        rst      = 1'b1;
        bus.EN   = 1'b1;
        bus.Data = 16'h1234;

        repeat (3) begin
            tick();
            chk("rst_an", bus.An, 4'hF);
            chk("rst_seg", bus.Seg, 7'h7F);
            chk("rst_fd", bus.Frame_Done, 0);
        end
        rst = 1'b0;
        tick();
        chk("entry_an", bus.An, 4'hF);
        chk("entry_fd", bus.Frame_Done, 0);

        frame("f1", 16'h1234, -1, 16'h0000);
        frame("f2", 16'h1234, 4, 16'hABCD);
        frame("f3", 16'hABCD, -1, 16'h0000);

        w = 16'hABCD;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("f4_an", bus.An, 4'hF ^ (4'b0001 << (i / 4)));
            chk("f4_seg", bus.Seg, seg_tab[w[(i/4)*4 +: 4]]);
        end
        bus.EN = 1'b0;
        tick();
        chk("drop_an", bus.An, 4'hF);
        chk("drop_seg", bus.Seg, 7'h7F);
        chk("drop_fd", bus.Frame_Done, 0);
        repeat (8) begin
            tick();
            chk("idle_an", bus.An, 4'hF);
            chk("idle_fd", bus.Frame_Done, 0);
        end

        bus.Data = 16'h1234;
        bus.EN   = 1'b1;
        tick();
        chk("reen_entry_an", bus.An, 4'hF);
        repeat (4) begin
            tick();
            chk("reen_d0_an", bus.An, 4'hE);
            chk("reen_d0_seg", bus.Seg, 7'h19);
        end
        tick();
        chk("reen_d1_an", bus.An, 4'hD);
        chk("reen_d1_seg", bus.Seg, 7'h30);
        repeat (10) begin
            tick();
            chk("prewrap_fd", bus.Frame_Done, 0);
        end
        bus.EN = 1'b0;
        tick();
        chk("wrapdrop_fd", bus.Frame_Done, 0);
        chk("wrapdrop_an", bus.An, 4'hF);
        tick();
        chk("wrapdrop_fd2", bus.Frame_Done, 0);

        bus.EN = 1'b1;
        tick();
        tick();
        tick();
        chk("prerst_an", bus.An, 4'hE);
        rst = 1'b1;
        tick();
        chk("midrst_an", bus.An, 4'hF);
        chk("midrst_seg", bus.Seg, 7'h7F);
        chk("midrst_fd", bus.Frame_Done, 0);
        rst    = 1'b0;
        bus.EN = 1'b0;
        bus.Data = 16'h0005;
        tick();
        bus.EN = 1'b1;
        tick();
        chk("lz_entry_an", bus.An, 4'hF);

        for (int i = 0; i < 16; i++) begin
            tick();
`ifdef ANODE_LZB_EN
            exp_an  = (i < 4) ? 4'hE : 4'hF;
            exp_seg = (i < 4) ? 7'h12 : 7'h7F;
`else
            exp_an  = 4'hF ^ (4'b0001 << (i / 4));
            exp_seg = (i < 4) ? 7'h12 : 7'h40;
`endif
            chk("d5_an", bus.An, exp_an);
            chk("d5_seg", bus.Seg, exp_seg);
            chk("d5_fd", bus.Frame_Done, (i == 15) ? 1 : 0);
            if (i == 4) bus.Data = 16'h0000;
        end
        for (int i = 0; i < 16; i++) begin
            tick();
`ifdef ANODE_LZB_EN
            exp_an  = (i < 4) ? 4'hE : 4'hF;
            exp_seg = (i < 4) ? 7'h40 : 7'h7F;
`else
            exp_an  = 4'hF ^ (4'b0001 << (i / 4));
            exp_seg = 7'h40;
`endif
            chk("d0_an", bus.An, exp_an);
            chk("d0_seg", bus.Seg, exp_seg);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
